// File: rtl/pfm_pkg.sv
// pfm_pkg: shared FSM encoding and constant helpers for period_freq_meter.
package pfm_pkg;
  typedef enum logic {ARM = 1'b0, GATE = 1'b1} pfm_state_e;
  function automatic int clog2(input longint v);
    int r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction
  function automatic int num_width(input int m, input int f_clk);
    return clog2(longint'(m) * longint'(f_clk) + 1);
  endfunction
  function automatic longint sat_val(input int w);
    return (longint'(1) << w) - 1;
  endfunction
endpackage

// File: rtl/pfm_seq_divider.sv
// pfm_seq_divider: restoring divider, one quotient bit per clock, saturating on
// overflow or zero denominator; done is asserted NUM_W clocks after start.
module pfm_seq_divider
  import pfm_pkg::*;
#(
  parameter int NUM_W = 21,
  parameter int DEN_W = 16,
  parameter int Q_W = 14
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic busy,
  output logic done,
  output logic [Q_W-1:0] quo
);
  localparam int CW = clog2(NUM_W + 1);
  localparam int W = (NUM_W > Q_W) ? NUM_W : Q_W;
  localparam logic [W-1:0] Q_MAX = W'(sat_val(Q_W));
  logic [NUM_W-1:0] q, q_next;
  logic [DEN_W-1:0] d, rem, rem_next;
  logic [DEN_W:0] trial;
  logic [CW-1:0] cnt;
  logic ge, dz, ovf;
  always_comb begin
    trial = {rem, q[NUM_W-1]};
    ge = trial >= {1'b0, d};
    rem_next = DEN_W'(trial - (ge ? {1'b0, d} : '0));
    q_next = (q << 1) | NUM_W'(ge);
    ovf = W'(q_next) > Q_MAX;
  end
  // busy stays high through the done cycle so it covers NUM_W+1 clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      q <= '0;
      d <= '0;
      rem <= '0;
      dz <= 1'b0;
      cnt <= '0;
      quo <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      done <= 1'b0;
      q <= num;
      d <= den;
      rem <= '0;
      dz <= den == '0;
      cnt <= '0;
    end else if (done) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (busy) begin
      q <= q_next;
      rem <= rem_next;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(NUM_W - 1)) begin
        done <= 1'b1;
        quo <= (dz || ovf) ? '1 : Q_W'(q_next);
      end
    end
  end
endmodule

// File: rtl/period_freq_meter.sv
// period_freq_meter: measures sig frequency over M periods in hundreds of Hz with
// hysteresis, loss timeout and update strobe; PFM_DIAG_EN adds the n_clk_out port.
module period_freq_meter
  import pfm_pkg::*;
#(
  parameter int F_CLK = 40000,
  parameter int M = 50,
  parameter int CNT_W = 16,
  parameter int F_W = 14,
  parameter int MIN_CHANGE = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  input  logic enable,
  output logic [F_W-1:0] f,
  output logic f_valid,
  output logic sig_lost,
  output logic busy
`ifdef PFM_DIAG_EN
  ,
  output logic [CNT_W-1:0] n_clk_out
`endif
);
  localparam int NUM_W = num_width(M, F_CLK);
  localparam int SIG_W = clog2(M + 1);
  localparam logic [NUM_W-1:0] NUM = NUM_W'(longint'(M) * longint'(F_CLK));
  localparam logic [CNT_W-1:0] N_SAT = CNT_W'(sat_val(CNT_W));
  localparam logic [SIG_W-1:0] LAST_SIG = SIG_W'(M - 1);
  localparam logic [CNT_W-1:0] HYST = CNT_W'(MIN_CHANGE);
  pfm_state_e state, state_n;
  logic s1, s2, s3, e;
  logic [CNT_W-1:0] n_clk, n_last, n_meas, n_diff;
  logic [SIG_W-1:0] n_sig;
  logic first_flag, sat_hit, meas_end, accept, timeout;
  logic div_start, div_abort, div_done;
  logic [F_W-1:0] quo;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {sig, s1, s2};
  end
  // a saturated n_clk wraps n_meas to 0, which the divider turns into all ones
  always_comb begin
    e = s2 & ~s3;
    sat_hit = n_clk == N_SAT;
    n_meas = n_clk + CNT_W'(1);
    n_diff = (n_meas > n_last) ? n_meas - n_last : n_last - n_meas;
    meas_end = (state == GATE) && e && (n_sig == LAST_SIG);
    accept = meas_end && (first_flag || n_diff > HYST);
    timeout = enable && !e && sat_hit;
    div_start = enable && accept && !busy;
    div_abort = !enable || timeout;
    state_n = (!enable || timeout) ? ARM : e ? GATE : state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARM;
      n_clk <= '0;
      n_sig <= '0;
    end else begin
      state <= state_n;
      if (!enable || timeout) begin
        n_clk <= '0;
        n_sig <= '0;
      end else begin
        n_clk <= (e && (state == ARM || meas_end)) ? '0 : sat_hit ? n_clk : n_clk + CNT_W'(1);
        n_sig <= (state == ARM || meas_end) ? '0 : n_sig + SIG_W'(e);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f <= '0;
      f_valid <= 1'b0;
      sig_lost <= 1'b1;
      n_last <= '0;
      first_flag <= 1'b1;
    end else begin
      f_valid <= 1'b0;
      if (enable && timeout) begin
        f <= '0;
        f_valid <= !sig_lost;
        sig_lost <= 1'b1;
        first_flag <= 1'b1;
      end else if (enable) begin
        if (div_done) begin
          f <= quo;
          f_valid <= 1'b1;
          sig_lost <= 1'b0;
        end
        if (div_start) begin
          n_last <= n_meas;
          first_flag <= 1'b0;
        end
      end
    end
  end
`ifdef PFM_DIAG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) n_clk_out <= '0;
    else if (enable && timeout) n_clk_out <= '0;
    else if (div_start) n_clk_out <= n_meas;
  end
`endif
  pfm_seq_divider #(
    .NUM_W(NUM_W),
    .DEN_W(CNT_W),
    .Q_W(F_W)
  ) u_div (
    .clk(clk),
    .reset_n(reset_n),
    .start(div_start),
    .abort(div_abort),
    .num(NUM),
    .den(n_meas),
    .busy(busy),
    .done(div_done),
    .quo(quo)
  );
endmodule
